// File: rtl/unsigned_alu_arbiter.sv
// rtl/unsigned_alu_arbiter.sv - two-requester round-robin shared add/sub with a registered result
// SAT_EN: when defined, results that overflow or borrow saturate instead of wrapping.
module unsigned_alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_ovf,
    output logic [7:0]       ovf_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             can_accept;
    logic             accept;
    logic             grant;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] sum_next;

    // rst_n gates acceptance so no ready is shown while reset is held
    assign can_accept = rst_n && ((state == EMPTY) || res_ready);
    assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign accept     = can_accept && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign res_valid  = (state == FULL);

    assign op_a   = grant ? req1_a  : req0_a;
    assign op_b   = grant ? req1_b  : req0_b;
    assign op_sub = grant ? req1_op : req0_op;

    // Bit WIDTH is the carry on add and the borrow (b > a) on subtract
    assign arith = op_sub ? ({1'b0, op_a} - {1'b0, op_b})
                          : ({1'b0, op_a} + {1'b0, op_b});

`ifdef SAT_EN
    always_comb begin
        sum_next = arith[WIDTH-1:0];
        if (arith[WIDTH]) begin
            sum_next = op_sub ? '0 : '1;
        end
    end
`else
    always_comb begin
        sum_next = arith[WIDTH-1:0];
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (res_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            res_id     <= 1'b0;
            res_sum    <= '0;
            res_ovf    <= 1'b0;
            ovf_cnt    <= 8'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= grant;
                res_id     <= grant;
                res_sum    <= sum_next;
                res_ovf    <= arith[WIDTH];
                if (arith[WIDTH] && (ovf_cnt != 8'hFF)) begin
                    ovf_cnt <= ovf_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_unsigned_alu_arbiter.sv
// tb/tb_unsigned_alu_arbiter.sv - randomized self-checking bench against a behavioural model
module tb_unsigned_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_op;
    logic [7:0] req1_a, req1_b;
    logic       res_valid, res_ready, res_id, res_ovf;
    logic [7:0] res_sum, ovf_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model of the result slot
    bit m_full, m_id, m_ovf, m_last;
    int m_sum, m_cnt;

`ifdef SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    unsigned_alu_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_sum(res_sum), .res_ovf(res_ovf), .ovf_cnt(ovf_cnt)
    );

    task automatic model_reset();
        m_full = 0; m_id = 0; m_ovf = 0; m_last = 1; m_sum = 0; m_cnt = 0;
    endtask

    // Inputs are set at a falling edge; checks grants, clocks once, checks the result slot.
    task automatic step(input string tag);
        bit can, g, acc, e0, e1, op;
        int a, b, r;
        #1;
        can = !m_full || res_ready;
        g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
        acc = can && (req0_valid || req1_valid);
        e0  = acc && !g;
        e1  = acc && g;
        n_cmp++;
        if (req0_ready !== e0 || req1_ready !== e1) begin
            n_bad++;
            $display("FAIL %s ready: got %b%b want %b%b", tag, req0_ready, req1_ready, e0, e1);
        end
        a  = g ? int'(req1_a) : int'(req0_a);
        b  = g ? int'(req1_b) : int'(req0_b);
        op = g ? req1_op : req0_op;
        @(posedge clk);
        if (acc) begin
            r      = op ? a - b : a + b;
            m_ovf  = op ? (b > a) : (r > 255);
            m_sum  = (m_ovf && SAT) ? (op ? 0 : 255) : (r & 255);
            m_id   = g;
            m_last = g;
            m_full = 1;
            if (m_ovf && m_cnt < 255) m_cnt++;
        end else if (res_ready) begin
            m_full = 0;
        end
        @(negedge clk);
        n_cmp++;
        if (res_valid !== m_full || ovf_cnt !== 8'(m_cnt)) begin
            n_bad++;
            $display("FAIL %s valid/cnt: got %b/%0d want %b/%0d", tag, res_valid, ovf_cnt, m_full, m_cnt);
        end
        if (m_full) begin
            n_cmp++;
            if (res_id !== m_id || res_sum !== 8'(m_sum) || res_ovf !== m_ovf) begin
                n_bad++;
                $display("FAIL %s result: got id%b sum%0d ovf%b want id%b sum%0d ovf%b",
                         tag, res_id, res_sum, res_ovf, m_id, m_sum, m_ovf);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; res_ready = 1;
        req0_valid = 1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 0;
        req1_valid = 1; req1_a = 8'd3; req1_b = 8'd4; req1_op = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (res_valid !== 0 || res_id !== 0 || res_sum !== 0 || res_ovf !== 0 || ovf_cnt !== 0 ||
            req0_ready !== 0 || req1_ready !== 0) begin
            n_bad++;
            $display("FAIL reset: got v%b id%b sum%0d ovf%b cnt%0d r%b%b want all zero",
                     res_valid, res_id, res_sum, res_ovf, ovf_cnt, req0_ready, req1_ready);
        end
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
    endtask

    task automatic test_directed();
        req0_valid = 1; req0_a = 8'd200; req0_b = 8'd100; req0_op = 0;
        step("add_ovf");
        n_cmp++;
        if (res_sum !== (SAT ? 8'd255 : 8'd44) || res_id !== 0 || res_ovf !== 1 || ovf_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL add_200_100: got sum%0d id%b ovf%b cnt%0d want sum%0d id0 ovf1 cnt1",
                     res_sum, res_id, res_ovf, ovf_cnt, SAT ? 255 : 44);
        end
        req0_valid = 0;
        req1_valid = 1; req1_a = 8'd10; req1_b = 8'd20; req1_op = 1;
        step("sub_borrow");
        n_cmp++;
        if (res_sum !== (SAT ? 8'd0 : 8'd246) || res_id !== 1 || res_ovf !== 1) begin
            n_bad++;
            $display("FAIL sub_10_20: got sum%0d id%b ovf%b want sum%0d id1 ovf1",
                     res_sum, res_id, res_ovf, SAT ? 0 : 246);
        end
        req1_a = 8'd20; req1_b = 8'd10;
        step("sub_plain");
        n_cmp++;
        if (res_sum !== 8'd10 || res_ovf !== 0) begin
            n_bad++;
            $display("FAIL sub_20_10: got sum%0d ovf%b want sum10 ovf0", res_sum, res_ovf);
        end
        req1_valid = 0;
    endtask

    task automatic test_alternate();
        bit want;
        want = 0;
        res_ready = 1;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom);
            step("alternate");
            n_cmp++;
            if (res_valid !== 1 || res_id !== want) begin
                n_bad++;
                $display("FAIL alternate[%0d]: got v%b id%b want v1 id%b", i, res_valid, res_id, want);
            end
            want = !want;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] h_sum;
        logic       h_id, h_ovf;
        res_ready = 1;
        req0_valid = 1; req1_valid = 1;
        step("bp_fill");
        h_sum = res_sum; h_id = res_id; h_ovf = res_ovf;
        res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            req0_a = 8'($urandom); req1_a = 8'($urandom);
            step("bp_hold");
            n_cmp++;
            if (res_sum !== h_sum || res_id !== h_id || res_ovf !== h_ovf || res_valid !== 1) begin
                n_bad++;
                $display("FAIL bp_stable[%0d]: got sum%0d id%b ovf%b want sum%0d id%b ovf%b",
                         i, res_sum, res_id, res_ovf, h_sum, h_id, h_ovf);
            end
        end
        res_ready = 1;
        step("bp_drain_refill");
        n_cmp++;
        if (res_valid !== 1 || res_id === h_id) begin
            n_bad++;
            $display("FAIL bp_refill: got v%b id%b want v1 id%b", res_valid, res_id, !h_id);
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            req0_valid = 1'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom);
            req1_valid = 1'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            step("random");
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_saturate_and_async_reset();
        res_ready = 1;
        req0_valid = 1; req0_a = 8'd255; req0_b = 8'd255; req0_op = 0;
        for (int i = 0; i < 300; i++) step("sat_cnt");
        n_cmp++;
        if (ovf_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL ovf_cnt_sat: got %0d want 255", ovf_cnt);
        end
        res_ready = 0;
        step("hold_full");
        #2 rst_n = 0;
        #1;
        model_reset();
        n_cmp++;
        if (res_valid !== 0 || ovf_cnt !== 0 || req0_ready !== 0) begin
            n_bad++;
            $display("FAIL async_reset: got v%b cnt%0d r0%b want v0 cnt0 r00", res_valid, ovf_cnt, req0_ready);
        end
        @(negedge clk);
        rst_n = 1;
        res_ready = 1;
        req0_a = 8'd3; req0_b = 8'd4;
        step("after_reset");
        req0_valid = 0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_alternate();
        test_back_to_back();
        test_random();
        test_saturate_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unsigned_alu_arbiter.md
UNSIGNED_ALU_ARBITER -- requirements
Module: unsigned_alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; only 8 is verified.
REQ-002 Port: clk  in  1  rising-edge clock, the only clock.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid  in  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  in  WIDTH  requester 0 unsigned operands.
REQ-007 Port: req0_op  in  1  requester 0 operation; 0 = a+b, 1 = a-b.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_op; same as REQ-004..007 for requester 1.
REQ-009 Port: res_valid  out  1  result register holds a valid result.
REQ-010 Port: res_ready  in  1  consumer takes the result this cycle.
REQ-011 Port: res_id  out  1  index of the requester that issued the result.
REQ-012 Port: res_sum  out  WIDTH  result value.
REQ-013 Port: res_ovf  out  1  carry-out on add, borrow (b > a) on sub.
REQ-014 Port: ovf_cnt  out  8  count of results with res_ovf=1, saturating at 255.

Function
REQ-015 A single shared WIDTH-bit adder/subtractor SHALL serve both requesters; at most one operation is accepted per cycle.
REQ-016 FSM states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-017 Transitions:
  - EMPTY->FULL on accept.
  - FULL->EMPTY on res_ready with no accept.
  - FULL->FULL on res_ready with accept (same-cycle drain and refill).
  - FULL holds while res_ready=0.
REQ-018 Accept is possible when state=EMPTY or res_ready=1; reqN_ready=1 only for the granted requester and only while accept is possible.
REQ-019 Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted most recently wins.
  - After reset, requester 0 has priority.
REQ-020 The last-grant pointer SHALL update only on an actual accept.
REQ-021 Latency: the result is registered; res_valid, res_id, res_sum and res_ovf appear the cycle after accept.
REQ-022 While FULL and res_ready=0, all res_* outputs SHALL hold stable.
REQ-023 Arithmetic: computed at WIDTH+1 bits.
  - add: res_ovf = bit WIDTH of the sum.
  - sub: res_ovf = (b > a).
  - Without saturation, res_sum = the result modulo 2^WIDTH.
REQ-024 ovf_cnt SHALL increment by 1 when a result with res_ovf=1 is loaded, and hold at 255.
REQ-025 Request inputs are sampled only on their accept cycle; a requester dropping valid without ready is permitted and ignored.

Reset
REQ-026 While rst_n=0, outputs SHALL be: state=EMPTY, res_valid=0, res_id=0, res_sum=0, res_ovf=0, ovf_cnt=0, last-grant=1 (requester 0 favoured), req0_ready=0, req1_ready=0.
REQ-027 Reset asserted mid-operation SHALL discard the held result immediately, with no clock required.
REQ-028 The first accept is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SAT_EN:
  - Defined: overflowed add gives res_sum = 2^WIDTH-1; borrowed sub gives res_sum = 0.
  - Undefined: wrap-around per REQ-023.
  - res_ovf and ovf_cnt behave identically in both builds.

Verification
REQ-030 req0 add a=200, b=100, res_ready=1 -> next cycle res_valid=1, res_id=0, res_ovf=1, res_sum=44 (SAT_EN: 255), ovf_cnt=1.
REQ-031 req1 sub a=10, b=20 -> res_sum=246 (SAT_EN: 0), res_ovf=1; sub a=20, b=10 -> res_sum=10, res_ovf=0.
REQ-032 Both valid continuously from reset, res_ready=1 -> grants alternate 0,1,0,1; results one per cycle with no bubbles.
REQ-033 res_ready=0 for 3 cycles while FULL -> req0_ready=req1_ready=0 and res_* stable; res_ready=1 -> drain and new accept in the same cycle.
REQ-034 300 overflowing operations -> ovf_cnt=255 and holds; rst_n pulsed low while FULL -> res_valid=0 and ovf_cnt=0 asynchronously.
